// File: rtl/ss_pkg.sv
// Shared types and constants for the save-state sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ss_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SAVE_SETTLE,
        S_RST_FETCH,
        S_RST_ARM,
        S_RST_STROBE,
        S_NEXT,
        S_FINISH
    } ss_state_t;

    localparam int SS_IDX_ADDR  = 127;
    localparam int SS_SLOTS_MAX = 256;

    localparam int CMD_START_BIT   = 0;
    localparam int CMD_RESTORE_BIT = 1;
    localparam int CMD_ABORT_BIT   = 2;

    typedef logic [2:0] ss_cmd_t;

    function automatic logic is_busy_state(input ss_state_t s);
        return (s != S_IDLE) && (s != S_FINISH);
    endfunction

endpackage

// File: rtl/ss_sequencer_if.sv
// Mapper save-state port plus state-buffer port, driven by the sequencer.
// Latency: n/a (wiring only).
// Backpressure: none; the mapper and buffer always accept.
interface ss_sequencer_if;
    logic       ss_act;
    logic       ss_we;
    logic [7:0] ss_addr;
    logic [7:0] ss_wdat;
    logic [7:0] ss_rdat;
    logic [7:0] buf_addr;
    logic [7:0] buf_wdat;
    logic       buf_we;
    logic [7:0] buf_rdat;

    modport master (
        output ss_act, ss_we, ss_addr, ss_wdat, buf_addr, buf_wdat, buf_we,
        input  ss_rdat, buf_rdat
    );

    modport slave (
        input  ss_act, ss_we, ss_addr, ss_wdat, buf_addr, buf_wdat, buf_we,
        output ss_rdat, buf_rdat
    );
endinterface

// File: rtl/ss_m2_wait.sv
// Counts m2_fall pulses while enabled and flags the n-th one (n >= 1).
// Latency: hit is combinational in the cycle of the n-th pulse.
// Backpressure: none; abort or dropping en clears the count.
module ss_m2_wait (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       abort,
    input  logic       m2_fall,
    input  logic [3:0] n,
    output logic       hit
);
    logic [3:0] cnt;

    assign hit = en && !abort && m2_fall && (({1'b0, cnt} + 5'd1) >= {1'b0, n});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en || abort || hit) begin
            cnt <= '0;
        end else if (m2_fall) begin
            cnt <= cnt + 4'd1;
        end
    end
endmodule

// File: rtl/ss_sequencer.sv
// Walks mapper save-state slots: save copies ss_rdat to the buffer, restore replays it.
// Latency: save SETTLE+2 clk per slot; restore up to 2 m2 periods per slot.
// Backpressure: restore stalls on missing m2_fall; only abort or reset exits.
module ss_sequencer
    import ss_pkg::*;
#(
    parameter int SS_WORDS = 128,
    parameter int SETTLE   = 2,
    parameter int IDX_ADDR = SS_IDX_ADDR
) (
    input  logic clk,
    input  logic rst_n,
    input  logic m2_fall,
    input  logic cmd_start,
    input  logic cmd_restore,
    input  logic cmd_abort,
    output logic busy,
    output logic done,
    output logic idx_err,
    ss_sequencer_if.master bus
);
    localparam logic [7:0] LAST_SLOT   = 8'(SS_WORDS - 1);
    localparam logic [7:0] IDX_SLOT    = 8'(IDX_ADDR);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

    ss_state_t  state;
    ss_cmd_t    cmd;
    logic [7:0] slot;
    logic [7:0] cnt;
    logic       restore;
    logic       wait_en;
    logic       m2_hit;

    logic       ss_act_q, ss_we_q, buf_we_q;
    logic [7:0] ss_addr_q, ss_wdat_q, buf_addr_q, buf_wdat_q;

    always_comb begin
        cmd = '0;
        cmd[CMD_START_BIT]   = cmd_start;
        cmd[CMD_RESTORE_BIT] = cmd_restore;
        cmd[CMD_ABORT_BIT]   = cmd_abort;
    end

    assign wait_en = (state == S_RST_ARM) || (state == S_RST_STROBE);

    ss_m2_wait u_m2_wait (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (wait_en),
        .abort   (cmd[CMD_ABORT_BIT]),
        .m2_fall (m2_fall),
        .n       (4'd1),
        .hit     (m2_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            slot       <= '0;
            cnt        <= '0;
            restore    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            idx_err    <= 1'b0;
            ss_act_q   <= 1'b0;
            ss_we_q    <= 1'b0;
            ss_addr_q  <= '0;
            ss_wdat_q  <= '0;
            buf_addr_q <= '0;
            buf_wdat_q <= '0;
            buf_we_q   <= 1'b0;
        end else begin
            done     <= 1'b0;
            buf_we_q <= 1'b0;
            if (is_busy_state(state) && cmd[CMD_ABORT_BIT]) begin
                // Partial progress stays in place; only the strobes are pulled.
                ss_we_q  <= 1'b0;
                ss_act_q <= 1'b0;
                busy     <= 1'b0;
                done     <= 1'b1;
                state    <= S_FINISH;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (cmd[CMD_START_BIT]) begin
                            slot     <= '0;
                            restore  <= cmd[CMD_RESTORE_BIT];
                            ss_act_q <= 1'b1;
                            busy     <= 1'b1;
                            idx_err  <= 1'b0;
                            state    <= S_SETUP;
                        end
                    end
                    S_SETUP: begin
                        ss_addr_q  <= slot;
                        buf_addr_q <= slot;
                        cnt        <= '0;
                        state      <= restore ? S_RST_FETCH : S_SAVE_SETTLE;
                    end
                    S_SAVE_SETTLE: begin
                        if (cnt == SETTLE_LAST) begin
                            buf_wdat_q <= bus.ss_rdat;
                            buf_we_q   <= 1'b1;
                            state      <= S_NEXT;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                    S_RST_FETCH: begin
                        if (cnt == 8'd0) begin
                            cnt <= 8'd1;
                        end else if (slot == IDX_SLOT) begin
                            // map_idx slot is read-only: verify, never write.
                            if (bus.buf_rdat != bus.ss_rdat) idx_err <= 1'b1;
                            state <= S_NEXT;
                        end else begin
                            ss_wdat_q <= bus.buf_rdat;
                            state     <= S_RST_ARM;
                        end
                    end
                    S_RST_ARM: begin
                        if (m2_hit) begin
                            ss_we_q <= 1'b1;
                            state   <= S_RST_STROBE;
                        end
                    end
                    S_RST_STROBE: begin
                        if (m2_hit) begin
                            ss_we_q <= 1'b0;
                            state   <= S_NEXT;
                        end
                    end
                    S_NEXT: begin
                        if (slot == LAST_SLOT) begin
                            ss_act_q <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= S_FINISH;
                        end else begin
                            slot  <= slot + 8'd1;
                            state <= S_SETUP;
                        end
                    end
                    S_FINISH: state <= S_IDLE;
                    default:  state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.ss_act   = ss_act_q;
    assign bus.ss_we    = ss_we_q;
    assign bus.ss_addr  = ss_addr_q;
    assign bus.ss_wdat  = ss_wdat_q;
    assign bus.buf_addr = buf_addr_q;
    assign bus.buf_wdat = buf_wdat_q;
    assign bus.buf_we   = buf_we_q;
endmodule

// File: tb/tb_ss_sequencer.sv
// Directed bench for ss_sequencer with mapper, state-buffer and m2 models.
module tb_ss_sequencer;
    localparam int M2_PER = 12;

    logic clk = 1'b0;
    logic rst_n;
    logic m2_fall;
    logic cmd_start, cmd_restore, cmd_abort;
    logic busy, done, idx_err;

    logic       m2_en;
    logic [7:0] map_idx;
    logic       fill_req, clr_req;
    logic [7:0] fill_base, fill_idx;

    int n_chk  = 0;
    int n_pass = 0;

    ss_sequencer_if bus();

    ss_sequencer #(.SS_WORDS(128), .SETTLE(2), .IDX_ADDR(127)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .m2_fall     (m2_fall),
        .cmd_start   (cmd_start),
        .cmd_restore (cmd_restore),
        .cmd_abort   (cmd_abort),
        .busy        (busy),
        .done        (done),
        .idx_err     (idx_err),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // m2 falling-edge pulse generator
    int m2_cnt;
    always @(posedge clk) begin
        if (!m2_en) begin
            m2_cnt  <= 0;
            m2_fall <= 1'b0;
        end else if (m2_cnt == M2_PER - 1) begin
            m2_cnt  <= 0;
            m2_fall <= 1'b1;
        end else begin
            m2_cnt  <= m2_cnt + 1;
            m2_fall <= 1'b0;
        end
    end

    // Mapper readback: slot 127 is map_idx, others a fixed pattern.
    assign bus.ss_rdat = (bus.ss_addr == 8'd127) ? map_idx : (bus.ss_addr ^ 8'hA5);

    // State buffer with synchronous read.
    logic [7:0] mem [0:255];
    always @(posedge clk) begin
        if (fill_req) begin
            for (int i = 0; i < 256; i++)
                mem[i] <= (i == 127) ? fill_idx : (8'(i) + fill_base);
        end else if (bus.buf_we) begin
            mem[bus.buf_addr] <= bus.buf_wdat;
        end
        bus.buf_rdat <= mem[bus.buf_addr];
    end

    // Mapper write recorder and strobe-shape monitor.
    int         wr_cnt [0:255];
    logic [7:0] wr_dat [0:255];
    int         buf_we_cnt, done_cnt, span_err, addr_chg_err, falls_in_we;
    logic       prev_we;
    logic [7:0] prev_addr;
    always @(posedge clk) begin
        if (clr_req) begin
            for (int i = 0; i < 256; i++) begin
                wr_cnt[i] <= 0;
                wr_dat[i] <= 8'h00;
            end
            buf_we_cnt   <= 0;
            done_cnt     <= 0;
            span_err     <= 0;
            addr_chg_err <= 0;
            falls_in_we  <= 0;
            prev_we      <= 1'b0;
            prev_addr    <= bus.ss_addr;
        end else begin
            if (bus.ss_we && m2_fall) begin
                wr_cnt[bus.ss_addr] <= wr_cnt[bus.ss_addr] + 1;
                wr_dat[bus.ss_addr] <= bus.ss_wdat;
            end
            if (bus.buf_we) buf_we_cnt <= buf_we_cnt + 1;
            if (done) done_cnt <= done_cnt + 1;
            if (bus.ss_we && (bus.ss_addr != prev_addr)) addr_chg_err <= addr_chg_err + 1;
            if (bus.ss_we) begin
                falls_in_we <= falls_in_we + (m2_fall ? 1 : 0);
            end else begin
                if (prev_we && falls_in_we != 1) span_err <= span_err + 1;
                falls_in_we <= 0;
            end
            prev_we   <= bus.ss_we;
            prev_addr <= bus.ss_addr;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
    endtask

    task automatic fill_buf(input logic [7:0] base, input logic [7:0] idx);
        fill_base = base;
        fill_idx  = idx;
        fill_req  = 1'b1;
        tick();
        fill_req  = 1'b0;
    endtask

    task automatic start(input logic rs);
        cmd_restore = rs;
        cmd_start   = 1'b1;
        tick();
        cmd_start   = 1'b0;
    endtask

    task automatic wait_done(input int max, input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            tick();
            if (done) ok = 1'b1;
        end
        if (!ok) check(tag, 32'd0, 32'd1);
    endtask

    int  cyc, errs, good, w;
    bit  ok, we_seen;

    initial begin
        rst_n = 1'b0; cmd_start = 1'b0; cmd_restore = 1'b0; cmd_abort = 1'b0;
        m2_en = 1'b0; map_idx = 8'h80; fill_req = 1'b0; clr_req = 1'b0;
        fill_base = 8'h00; fill_idx = 8'h00;
        #23;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_idx_err", idx_err, 0);
        check("rst_ss_act", bus.ss_act, 0);
        check("rst_ss_we", bus.ss_we, 0);
        check("rst_buf_we", bus.buf_we, 0);
        check("rst_ss_addr", bus.ss_addr, 0);
        check("rst_buf_addr", bus.buf_addr, 0);
        check("rst_ss_wdat", bus.ss_wdat, 0);
        check("rst_buf_wdat", bus.buf_wdat, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Save all 128 slots; timing does not depend on m2.
        clear_model();
        start(1'b0);
        check("save_busy", busy, 1);
        check("save_ss_act", bus.ss_act, 1);
        cyc = 0; ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            tick();
            cyc++;
            if (done) ok = 1'b1;
        end
        check("save_done", ok, 1);
        check("save_latency", cyc, 512);
        tick(); tick();
        check("save_buf_we_cnt", buf_we_cnt, 128);
        check("save_done_cnt", done_cnt, 1);
        check("save_busy_after", busy, 0);
        check("save_ss_act_after", bus.ss_act, 0);
        errs = 0;
        for (int i = 0; i < 128; i++)
            if (mem[i] !== ((i == 127) ? 8'h80 : (8'(i) ^ 8'hA5))) errs++;
        check("save_buf_content", errs, 0);

        // Restore buffer[i]=i+1 with matching map_idx.
        fill_buf(8'h01, 8'h80);
        map_idx = 8'h80;
        clear_model();
        m2_en = 1'b1;
        start(1'b1);
        wait_done(6000, "rst_timeout");
        tick(); tick();
        errs = 0;
        for (int i = 0; i < 127; i++)
            if (wr_cnt[i] != 1 || wr_dat[i] !== 8'(i + 1)) errs++;
        check("rst_slot_writes", errs, 0);
        check("rst_idx_no_write", wr_cnt[127], 0);
        check("rst_idx_err", idx_err, 0);
        check("rst_we_span", span_err, 0);
        check("rst_we_addr_chg", addr_chg_err, 0);
        check("rst_done_cnt", done_cnt, 1);
        check("rst_busy_after", busy, 0);

        // map_idx mismatch: slot 127 verified, flagged, not written.
        fill_buf(8'h01, 8'h20);
        map_idx = 8'h21;
        clear_model();
        start(1'b1);
        wait_done(6000, "idx_timeout");
        tick();
        check("idx_err_set", idx_err, 1);
        check("idx_no_write", wr_cnt[127], 0);
        good = 0;
        for (int i = 0; i < 127; i++)
            if (wr_cnt[i] == 1) good++;
        check("idx_other_writes", good, 127);
        tick();
        check("idx_err_sticky", idx_err, 1);

        // Abort on the arming m2_fall of slot 5.
        fill_buf(8'h01, 8'h80);
        map_idx = 8'h80;
        clear_model();
        start(1'b1);
        check("abort_idx_err_cleared", idx_err, 0);
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            tick();
            if (bus.ss_addr == 8'd5) ok = 1'b1;
        end
        check("abort_reach_slot5", ok, 1);
        w = 0; ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            tick();
            w++;
            if (w >= 2 && m2_fall && !bus.ss_we) ok = 1'b1;
        end
        check("abort_arm_fall", ok, 1);
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        check("abort_done", done, 1);
        check("abort_busy", busy, 0);
        check("abort_ss_we", bus.ss_we, 0);
        check("abort_ss_act", bus.ss_act, 0);
        tick();
        good = 0;
        for (int i = 0; i < 5; i++)
            if (wr_cnt[i] == 1 && wr_dat[i] === 8'(i + 1)) good++;
        check("abort_slots_0_4", good, 5);
        check("abort_slot5_unwritten", wr_cnt[5], 0);

        // Async reset mid-save at slot 7, then restart from slot 0.
        clear_model();
        start(1'b0);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            tick();
            if (bus.ss_addr == 8'd7) ok = 1'b1;
        end
        check("arst_reach_slot7", ok, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_ss_act", bus.ss_act, 0);
        check("arst_ss_addr", bus.ss_addr, 0);
        check("arst_buf_addr", bus.buf_addr, 0);
        check("arst_buf_we", bus.buf_we, 0);
        tick();
        rst_n = 1'b1;
        tick();
        clear_model();
        start(1'b0);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (bus.buf_we) ok = 1'b1;
            else tick();
        end
        check("arst_first_we", ok, 1);
        check("arst_restart_slot", bus.buf_addr, 0);
        wait_done(1000, "arst_timeout");
        tick();
        check("arst_full_save", buf_we_cnt, 128);

        // m2 stopped during restore; a second start is ignored.
        m2_en = 1'b0;
        clear_model();
        start(1'b1);
        repeat (5) tick();
        start(1'b0);
        we_seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (bus.ss_we) we_seen = 1'b1;
        end
        check("stall_busy", busy, 1);
        check("stall_no_ss_we", we_seen, 0);
        check("stall_no_buf_we", buf_we_cnt, 0);
        check("stall_ss_act", bus.ss_act, 1);
        check("stall_slot", bus.ss_addr, 0);
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        check("stall_abort_done", done, 1);
        check("stall_abort_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
